// File: rtl/sdram_req_scheduler.sv
`default_nettype none
// ============================================================================
// sdram_req_scheduler : drains the AXI->SDRAM CDC FIFO bank and issues one
// SDRAM command at a time. Optional macro SCHED_RD_TIMEOUT_EN adds a
// read-response timeout with sticky ERR.   Rev 1.0
// ============================================================================
module sdram_req_scheduler #(
  parameter int SIZE    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            SD_CLK,
  input  logic            SD_RST,
  input  logic            RW_FIFO_EMPTY,
  output logic            SD_RW_EN,
  input  logic            SD_RW_OUT,
  input  logic            WADDR_FIFO_EMPTY,
  input  logic            WDATA_FIFO_EMPTY,
  output logic            SD_WR_ADDR_EN,
  output logic            SD_WR_DATA_EN,
  input  logic [SIZE-1:0] SD_WR_ADDR_OUT,
  input  logic [SIZE-1:0] SD_WR_DATA_OUT,
  input  logic            RADDR_FIFO_EMPTY,
  output logic            SD_RD_ADDR_EN,
  input  logic [SIZE-1:0] SD_RD_ADDR_OUT,
  input  logic            RDATA_FIFO_FULL,
  output logic            SD_RD_DATA_EN,
  output logic [SIZE-1:0] SD_RD_DATA_IN,
  input  logic            REF_REQ,
  output logic            REF_ACK,
  output logic            CMD_VALID,
  input  logic            CMD_READY,
  output logic            CMD_WRITE,
  output logic [SIZE-1:0] CMD_ADDR,
  output logic [SIZE-1:0] CMD_WDATA,
  input  logic            RSP_VALID,
  input  logic [SIZE-1:0] RSP_DATA,
  output logic            BUSY,
  output logic            ERR
);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_REFRESH = 4'd1;
  localparam logic [3:0] S_DECODE  = 4'd2;
  localparam logic [3:0] S_WR_WAIT = 4'd3;
  localparam logic [3:0] S_WR_LAT  = 4'd4;
  localparam logic [3:0] S_RD_WAIT = 4'd5;
  localparam logic [3:0] S_RD_LAT  = 4'd6;
  localparam logic [3:0] S_CMD     = 4'd7;
  localparam logic [3:0] S_RD_RSP  = 4'd8;
  localparam logic [3:0] S_RD_PUSH = 4'd9;

  logic [3:0]      state_q, state_d;
  logic            cmd_write_q, cmd_write_d;
  logic [SIZE-1:0] cmd_addr_q, cmd_addr_d;
  logic [SIZE-1:0] cmd_wdata_q, cmd_wdata_d;
  logic [SIZE-1:0] rd_data_q, rd_data_d;
  logic            rsp_valid_q;
  logic [SIZE-1:0] rsp_data_q;
  logic            timeout_w;
  logic            w_rw_go, w_wr_go, w_rd_go;

  assign w_rw_go = !REF_REQ && !RW_FIFO_EMPTY;
  assign w_wr_go = !WADDR_FIFO_EMPTY && !WDATA_FIFO_EMPTY;
  assign w_rd_go = !RADDR_FIFO_EMPTY && !RDATA_FIFO_FULL;

`ifdef SCHED_RD_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  assign timeout_w = (state_q == S_RD_RSP) && (cnt_q == CNT_W'(TIMEOUT - 1));
  assign ERR       = err_q;

  // Counter idles at zero outside RD_RSP, so it is clear on every entry.
  always_ff @(posedge SD_CLK) begin
    if (SD_RST) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_q != S_RD_RSP)
        cnt_q <= '0;
      else if (!timeout_w)
        cnt_q <= cnt_q + 1'b1;
      if (timeout_w && !rsp_valid_q)
        err_q <= 1'b1;
    end
  end
`else
  logic unused_timeout_w;
  assign unused_timeout_w = ^TIMEOUT;
  assign timeout_w        = 1'b0;
  assign ERR              = 1'b0;
`endif

  always_ff @(posedge SD_CLK) begin
    if (SD_RST) begin
      state_q     <= S_IDLE;
      cmd_write_q <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      rd_data_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cmd_write_q <= cmd_write_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      rd_data_q   <= rd_data_d;
      // Response is registered first, giving the two-cycle RSP_VALID->push latency.
      rsp_valid_q <= RSP_VALID && (state_q == S_RD_RSP);
      rsp_data_q  <= RSP_DATA;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (REF_REQ) state_d = S_REFRESH;
                 else if (!RW_FIFO_EMPTY) state_d = S_DECODE;
      S_REFRESH: state_d = S_IDLE;
      S_DECODE:  state_d = SD_RW_OUT ? S_WR_WAIT : S_RD_WAIT;
      S_WR_WAIT: if (w_wr_go) state_d = S_WR_LAT;
      S_WR_LAT:  state_d = S_CMD;
      S_RD_WAIT: if (w_rd_go) state_d = S_RD_LAT;
      S_RD_LAT:  state_d = S_CMD;
      S_CMD:     if (CMD_READY) state_d = cmd_write_q ? S_IDLE : S_RD_RSP;
      S_RD_RSP:  if (rsp_valid_q || timeout_w) state_d = S_RD_PUSH;
      S_RD_PUSH: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_write_d = cmd_write_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    rd_data_d   = rd_data_q;
    case (state_q)
      S_DECODE: cmd_write_d = SD_RW_OUT;
      S_WR_LAT: begin
        cmd_addr_d  = SD_WR_ADDR_OUT;
        cmd_wdata_d = SD_WR_DATA_OUT;
      end
      S_RD_LAT: cmd_addr_d = SD_RD_ADDR_OUT;
      S_RD_RSP: begin
        if (rsp_valid_q)    rd_data_d = rsp_data_q;
        else if (timeout_w) rd_data_d = '1;
      end
      default: ;
    endcase
  end

  // Strobes are masked during reset so no FIFO entry is popped while held.
  always_comb begin
    SD_RW_EN      = 1'b0;
    SD_WR_ADDR_EN = 1'b0;
    SD_WR_DATA_EN = 1'b0;
    SD_RD_ADDR_EN = 1'b0;
    SD_RD_DATA_EN = 1'b0;
    REF_ACK       = 1'b0;
    CMD_VALID     = 1'b0;
    BUSY          = 1'b0;
    if (!SD_RST) begin
      BUSY = (state_q != S_IDLE);
      case (state_q)
        S_IDLE:    SD_RW_EN = w_rw_go;
        S_REFRESH: REF_ACK = 1'b1;
        S_WR_WAIT: begin
          SD_WR_ADDR_EN = w_wr_go;
          SD_WR_DATA_EN = w_wr_go;
        end
        S_RD_WAIT: SD_RD_ADDR_EN = w_rd_go;
        S_CMD:     CMD_VALID = 1'b1;
        S_RD_PUSH: SD_RD_DATA_EN = 1'b1;
        default: ;
      endcase
    end
  end

  assign CMD_WRITE     = cmd_write_q;
  assign CMD_ADDR      = cmd_addr_q;
  assign CMD_WDATA     = cmd_wdata_q;
  assign SD_RD_DATA_IN = rd_data_q;

endmodule
`default_nettype wire

// File: tb/tb_sdram_req_scheduler.sv
`default_nettype none
// tb_sdram_req_scheduler : scoreboard bench; FIFO bank, command core and
// responder are modelled inside the single stimulus process.
`timescale 1ns/1ps
module tb_sdram_req_scheduler;
  localparam int SIZE    = 32;
  localparam int TIMEOUT = 16;

  logic            SD_CLK = 1'b0, SD_RST = 1'b1;
  logic            RW_FIFO_EMPTY = 1'b1, SD_RW_OUT = 1'b0;
  logic            WADDR_FIFO_EMPTY = 1'b1, WDATA_FIFO_EMPTY = 1'b1, RADDR_FIFO_EMPTY = 1'b1;
  logic [SIZE-1:0] SD_WR_ADDR_OUT = '0, SD_WR_DATA_OUT = '0, SD_RD_ADDR_OUT = '0, RSP_DATA = '0;
  logic            RDATA_FIFO_FULL = 1'b0, REF_REQ = 1'b0, CMD_READY = 1'b0, RSP_VALID = 1'b0;
  logic            SD_RW_EN, SD_WR_ADDR_EN, SD_WR_DATA_EN, SD_RD_ADDR_EN, SD_RD_DATA_EN;
  logic            REF_ACK, CMD_VALID, CMD_WRITE, BUSY, ERR;
  logic [SIZE-1:0] SD_RD_DATA_IN, CMD_ADDR, CMD_WDATA;

  always #5 SD_CLK = ~SD_CLK;

  sdram_req_scheduler #(.SIZE(SIZE), .TIMEOUT(TIMEOUT)) dut (
    .SD_CLK(SD_CLK), .SD_RST(SD_RST),
    .RW_FIFO_EMPTY(RW_FIFO_EMPTY), .SD_RW_EN(SD_RW_EN), .SD_RW_OUT(SD_RW_OUT),
    .WADDR_FIFO_EMPTY(WADDR_FIFO_EMPTY), .WDATA_FIFO_EMPTY(WDATA_FIFO_EMPTY),
    .SD_WR_ADDR_EN(SD_WR_ADDR_EN), .SD_WR_DATA_EN(SD_WR_DATA_EN),
    .SD_WR_ADDR_OUT(SD_WR_ADDR_OUT), .SD_WR_DATA_OUT(SD_WR_DATA_OUT),
    .RADDR_FIFO_EMPTY(RADDR_FIFO_EMPTY), .SD_RD_ADDR_EN(SD_RD_ADDR_EN),
    .SD_RD_ADDR_OUT(SD_RD_ADDR_OUT), .RDATA_FIFO_FULL(RDATA_FIFO_FULL),
    .SD_RD_DATA_EN(SD_RD_DATA_EN), .SD_RD_DATA_IN(SD_RD_DATA_IN),
    .REF_REQ(REF_REQ), .REF_ACK(REF_ACK),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WRITE(CMD_WRITE),
    .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA),
    .RSP_VALID(RSP_VALID), .RSP_DATA(RSP_DATA), .BUSY(BUSY), .ERR(ERR)
  );

  typedef struct {
    logic            wr;
    logic [SIZE-1:0] addr;
    logic [SIZE-1:0] wdata;
  } cmd_t;

  cmd_t            exp_cmd[$];
  logic [SIZE-1:0] exp_rd[$];
  logic            rw_fifo[$];
  logic [SIZE-1:0] waddr_fifo[$], wdata_fifo[$], raddr_fifo[$], rsp_fifo[$];

  int tests = 0, fails = 0, cyc = 0;
  int ready_delay = 0, rsp_delay = 0, vcnt = 0, rsp_due = -1;
  int t_rwen = 0, t_wstb = 0, t_rstb = 0, t_vfirst = 0, t_hs = 0, t_rsp = 0, t_push = 0, t_ref = 0;
  int n_hs = 0, n_push = 0, n_ref = 0, n_valid = 0, n_rstb = 0;
  int rwen_cyc[$], hs_cyc[$], push_cyc[$];
  logic            en_rw, en_wr, en_rd, prev_valid = 1'b0, prev_ready = 1'b0, prev_write = 1'b0;
  logic [SIZE-1:0] prev_addr = '0, prev_wdata = '0;
  logic            s_busy, s_err, s_valid;

  task automatic update_flags();
    RW_FIFO_EMPTY    = (rw_fifo.size() == 0);
    WADDR_FIFO_EMPTY = (waddr_fifo.size() == 0);
    WDATA_FIFO_EMPTY = (wdata_fifo.size() == 0);
    RADDR_FIFO_EMPTY = (raddr_fifo.size() == 0);
  endtask

  task automatic push_write(input logic [SIZE-1:0] a, input logic [SIZE-1:0] d);
    cmd_t c;
    c.wr = 1'b1; c.addr = a; c.wdata = d;
    waddr_fifo.push_back(a); wdata_fifo.push_back(d); exp_cmd.push_back(c);
    rw_fifo.push_back(1'b1);
    update_flags();
  endtask

  task automatic push_read(input logic [SIZE-1:0] a, input logic [SIZE-1:0] rsp, input logic expect_push);
    cmd_t c;
    c.wr = 1'b0; c.addr = a; c.wdata = '0;
    raddr_fifo.push_back(a); rsp_fifo.push_back(rsp); exp_cmd.push_back(c);
    if (expect_push) exp_rd.push_back(rsp);
    rw_fifo.push_back(1'b0);
    update_flags();
  endtask

  // One clock: observe at negedge, then model FIFO pops / READY / RSP just after posedge.
  task automatic step();
    cmd_t e;
    @(negedge SD_CLK);
    cyc++;
    en_rw = SD_RW_EN; en_wr = SD_WR_ADDR_EN; en_rd = SD_RD_ADDR_EN;
    s_busy = BUSY; s_err = ERR; s_valid = CMD_VALID;
    if (SD_RW_EN) begin
      tests++; t_rwen = cyc; rwen_cyc.push_back(cyc);
      if (RW_FIFO_EMPTY !== 1'b0) begin fails++; $display("FAIL rw_pop_empty cyc=%0d", cyc); end
    end
    if (SD_WR_ADDR_EN || SD_WR_DATA_EN) begin
      tests++; t_wstb = cyc;
      if ({SD_WR_ADDR_EN, SD_WR_DATA_EN, WADDR_FIFO_EMPTY, WDATA_FIFO_EMPTY} !== 4'b1100) begin
        fails++; $display("FAIL wr_pop_pair cyc=%0d got en=%b%b empty=%b%b want 11/00", cyc,
                          SD_WR_ADDR_EN, SD_WR_DATA_EN, WADDR_FIFO_EMPTY, WDATA_FIFO_EMPTY);
      end
    end
    if (SD_RD_ADDR_EN) begin
      tests++; t_rstb = cyc; n_rstb++;
      if ({RADDR_FIFO_EMPTY, RDATA_FIFO_FULL} !== 2'b00) begin
        fails++; $display("FAIL rd_pop_blocked cyc=%0d empty=%b full=%b", cyc, RADDR_FIFO_EMPTY, RDATA_FIFO_FULL);
      end
    end
    if (REF_ACK) begin n_ref++; t_ref = cyc; end
    if (RSP_VALID) t_rsp = cyc;
    if (CMD_VALID) begin
      n_valid++;
      if (!prev_valid) t_vfirst = cyc;
      if (prev_valid && !prev_ready) begin
        tests++;
        if ({CMD_WRITE, CMD_ADDR, CMD_WDATA} !== {prev_write, prev_addr, prev_wdata}) begin
          fails++; $display("FAIL cmd_stable cyc=%0d got %b/%h/%h want %b/%h/%h", cyc,
                            CMD_WRITE, CMD_ADDR, CMD_WDATA, prev_write, prev_addr, prev_wdata);
        end
      end
      if (CMD_READY) begin
        n_hs++; t_hs = cyc; hs_cyc.push_back(cyc); vcnt = 0; tests++;
        if (exp_cmd.size() == 0) begin
          fails++; $display("FAIL cmd_unexpected cyc=%0d got %b/%h want none", cyc, CMD_WRITE, CMD_ADDR);
        end else begin
          e = exp_cmd.pop_front();
          if (CMD_WRITE !== e.wr || CMD_ADDR !== e.addr || (e.wr && CMD_WDATA !== e.wdata)) begin
            fails++; $display("FAIL cmd_fields cyc=%0d got %b/%h/%h want %b/%h/%h", cyc,
                              CMD_WRITE, CMD_ADDR, CMD_WDATA, e.wr, e.addr, e.wdata);
          end
          if (!e.wr && rsp_delay >= 0) rsp_due = cyc + rsp_delay;
        end
      end else vcnt++;
    end
    prev_valid = CMD_VALID; prev_ready = CMD_READY;
    prev_write = CMD_WRITE; prev_addr = CMD_ADDR; prev_wdata = CMD_WDATA;
    if (SD_RD_DATA_EN) begin
      n_push++; t_push = cyc; push_cyc.push_back(cyc); tests++;
      if (exp_rd.size() == 0) begin
        fails++; $display("FAIL rd_push_unexpected cyc=%0d got %h want none", cyc, SD_RD_DATA_IN);
      end else if (SD_RD_DATA_IN !== exp_rd[0]) begin
        fails++; $display("FAIL rd_push_data cyc=%0d got %h want %h", cyc, SD_RD_DATA_IN, exp_rd[0]);
        void'(exp_rd.pop_front());
      end else void'(exp_rd.pop_front());
    end
    @(posedge SD_CLK);
    #1;
    if (en_rw && rw_fifo.size() > 0) SD_RW_OUT = rw_fifo.pop_front();
    if (en_wr && waddr_fifo.size() > 0) SD_WR_ADDR_OUT = waddr_fifo.pop_front();
    if (en_wr && wdata_fifo.size() > 0) SD_WR_DATA_OUT = wdata_fifo.pop_front();
    if (en_rd && raddr_fifo.size() > 0) SD_RD_ADDR_OUT = raddr_fifo.pop_front();
    update_flags();
    CMD_READY = (ready_delay == 0) ? 1'b1 : (vcnt >= ready_delay);
    if ((cyc + 1) == rsp_due) begin
      RSP_VALID = 1'b1;
      RSP_DATA  = (rsp_fifo.size() > 0) ? rsp_fifo.pop_front() : '0;
    end else RSP_VALID = 1'b0;
  endtask

  // which: 0 = handshakes, 1 = read pushes, 2 = CMD_VALID cycles, 3 = refresh acks
  task automatic wait_count(input int which, input int target, input int budget, input string name);
    int k = 0;
    int v;
    v = (which == 0) ? n_hs : (which == 1) ? n_push : (which == 2) ? n_valid : n_ref;
    while (v < target && k < budget) begin
      step(); k++;
      v = (which == 0) ? n_hs : (which == 1) ? n_push : (which == 2) ? n_valid : n_ref;
      if (which == 3 && v >= target) REF_REQ = 1'b0;
    end
    tests++;
    if (v < target) begin fails++; $display("FAIL %s_timeout got %0d want %0d", name, v, target); end
  endtask

  task automatic check(input string name, input int got, input int want);
    tests++;
    if (got != want) begin fails++; $display("FAIL %s got %0d want %0d", name, got, want); end
  endtask

  task automatic test_reset();
    SD_RST = 1'b1;
    step(); step();
    tests++;
    if ({SD_RW_EN, SD_WR_ADDR_EN, SD_WR_DATA_EN, SD_RD_ADDR_EN, SD_RD_DATA_EN, REF_ACK,
         CMD_VALID, CMD_WRITE, BUSY, ERR, CMD_ADDR, CMD_WDATA, SD_RD_DATA_IN} !== '0) begin
      fails++; $display("FAIL reset_outputs got busy=%b valid=%b addr=%h want all zero", BUSY, CMD_VALID, CMD_ADDR);
    end
    SD_RST = 1'b0;
    step();
    check("reset_idle_busy", int'(s_busy), 0);
  endtask

  task automatic test_single_write();
    int v0;
    ready_delay = 0; CMD_READY = 1'b1; rwen_cyc.delete();
    v0 = n_valid;
    push_write(32'h100, 32'hA5A5_A5A5);
    wait_count(0, n_hs + 1, 20, "write_hs");
    check("write_strobe_lat", t_wstb - rwen_cyc[0], 2);
    check("write_valid_lat", t_vfirst - rwen_cyc[0], 4);
    check("write_hs_lat", t_hs - rwen_cyc[0], 4);
    step();
    check("write_busy_low", int'(s_busy), 0);
    check("write_valid_cycles", n_valid - v0, 1);
  endtask

  task automatic test_single_read();
    int p0;
    rsp_delay = 3; rwen_cyc.delete(); p0 = n_push;
    push_read(32'h200, 32'h1234_5678, 1'b1);
    wait_count(1, p0 + 1, 40, "read_push");
    check("read_strobe_lat", t_rstb - rwen_cyc[0], 2);
    check("read_valid_lat", t_vfirst - rwen_cyc[0], 4);
    check("read_rsp_to_push", t_push - t_rsp, 2);
    step(); step();
    check("read_push_once", n_push - p0, 1);
  endtask

  task automatic test_ordering();
    int v0;
    ready_delay = 3; rsp_delay = 2; v0 = n_valid;
    push_write(32'h300, 32'h1111_1111);
    push_read(32'h304, 32'hCAFE_F00D, 1'b1);
    push_write(32'h308, 32'h2222_2222);
    wait_count(0, n_hs + 3, 120, "order_hs");
    check("order_valid_cycles", n_valid - v0, 12);
    check("order_cmds_left", exp_cmd.size(), 0);
    ready_delay = 0;
    step();
  endtask

  task automatic test_backpressure();
    int r0, v0, t_rel;
    RDATA_FIFO_FULL = 1'b1; rsp_delay = 1; r0 = n_rstb; v0 = n_valid;
    push_read(32'h400, 32'h55AA_55AA, 1'b1);
    repeat (12) step();
    check("bp_no_rd_pop", n_rstb - r0, 0);
    check("bp_no_valid", n_valid - v0, 0);
    check("bp_busy", int'(s_busy), 1);
    RDATA_FIFO_FULL = 1'b0; t_rel = cyc + 1;
    wait_count(1, n_push + 1, 30, "bp_push");
    check("bp_rd_pop_after_release", t_rstb, t_rel);
  endtask

  task automatic test_refresh();
    int r0;
    ready_delay = 0; r0 = n_ref;
    REF_REQ = 1'b1;
    push_write(32'h500, 32'h0F0F_0F0F);
    wait_count(3, r0 + 1, 10, "ref_idle_ack");
    wait_count(0, n_hs + 1, 20, "ref_idle_hs");
    check("ref_before_rw_pop", t_rwen - t_ref, 1);
    check("ref_ack_once", n_ref - r0, 1);
    ready_delay = 3;
    push_write(32'h504, 32'hF0F0_F0F0);
    wait_count(2, n_valid + 1, 20, "ref_cmd_valid");
    REF_REQ = 1'b1;
    wait_count(3, n_ref + 1, 20, "ref_mid_ack");
    check("ref_after_txn", t_ref - t_hs, 2);
    ready_delay = 0;
  endtask

  task automatic test_back_to_back();
    ready_delay = 0; rsp_delay = 1;
    rwen_cyc.delete(); hs_cyc.delete(); push_cyc.delete();
    push_write(32'h600, 32'h6666_6666);
    push_read(32'h604, 32'h0BAD_BEEF, 1'b1);
    push_write(32'h608, 32'h8888_8888);
    wait_count(0, n_hs + 3, 60, "b2b_hs");
    check("b2b_pops", rwen_cyc.size(), 3);
    if (rwen_cyc.size() == 3 && hs_cyc.size() >= 1 && push_cyc.size() >= 1) begin
      check("b2b_after_write", rwen_cyc[1] - hs_cyc[0], 1);
      check("b2b_after_read", rwen_cyc[2] - push_cyc[0], 1);
    end
    step();
  endtask

  task automatic test_timeout_and_reset();
    ready_delay = 0; rsp_delay = -1;
`ifdef SCHED_RD_TIMEOUT_EN
    push_read(32'h700, 32'h0, 1'b0);
    exp_rd.push_back({SIZE{1'b1}});
    wait_count(1, n_push + 1, 60, "to_push");
    check("to_push_lat", t_push - t_hs, TIMEOUT + 1);
    check("to_err_set", int'(s_err), 1);
    step(); step();
    check("to_err_sticky", int'(s_err), 1);
`else
    push_read(32'h700, 32'h0, 1'b0);
    begin
      int p0;
      p0 = n_push;
      repeat (40) step();
      check("nto_no_push", n_push - p0, 0);
      check("nto_still_busy", int'(s_busy), 1);
      check("nto_err_zero", int'(s_err), 0);
    end
`endif
    SD_RST = 1'b1; step(); SD_RST = 1'b0; step();
    check("rst_err_clear", int'(s_err), 0);
    check("rst_busy_clear", int'(s_busy), 0);
    ready_delay = 1000; rsp_delay = 0;
    push_write(32'h800, 32'h8080_8080);
    wait_count(2, n_valid + 1, 20, "rst_cmd_valid");
    SD_RST = 1'b1; step(); step();
    check("rst_drops_valid", int'(s_valid), 0);
    check("rst_drops_busy", int'(s_busy), 0);
    exp_cmd.delete(); rsp_due = -1;
    SD_RST = 1'b0; ready_delay = 0;
    step(); step();
    check("rst_stays_idle", int'(s_busy), 0);
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_single_read();
    test_ordering();
    test_backpressure();
    test_refresh();
    test_back_to_back();
    test_timeout_and_reset();
    check("final_cmds_left", exp_cmd.size(), 0);
    check("final_rd_left", exp_rd.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sdram_req_scheduler.md
# sdram_req_scheduler

SDRAM-clock-domain sequencer that drains the AXI-to-SDRAM clock-crossing FIFO bank and drives the SDRAM command core. It pops the read/write ordering bit, then the matching address (and, for writes, data) entries. It issues one command at a time over a valid/ready handshake and pushes read responses into the read-data FIFO. Refresh requests take priority between transactions.

## Interface
Parameters:
- SIZE, 32, address/data width.
- TIMEOUT, 255, read-response timeout in SD_CLK cycles; used only with SCHED_RD_TIMEOUT_EN.

Ports:
- SD_CLK  in  1  SDRAM-domain clock; all logic on its rising edge.
- SD_RST  in  1  synchronous, active-high reset.
- RW_FIFO_EMPTY  in  1  ordering FIFO empty.
- SD_RW_EN  out  1  ordering FIFO pop strobe.
- SD_RW_OUT  in  1  popped ordering bit: 1 = write, 0 = read.
- WADDR_FIFO_EMPTY, WDATA_FIFO_EMPTY  in  1 each  write FIFOs empty.
- SD_WR_ADDR_EN, SD_WR_DATA_EN  out  1 each  write FIFO pop strobes.
- SD_WR_ADDR_OUT, SD_WR_DATA_OUT  in  SIZE each  popped write address/data.
- RADDR_FIFO_EMPTY  in  1  read-address FIFO empty.
- SD_RD_ADDR_EN  out  1  read-address pop strobe.
- SD_RD_ADDR_OUT  in  SIZE  popped read address.
- RDATA_FIFO_FULL  in  1  read-data FIFO full.
- SD_RD_DATA_EN  out  1  read-data push strobe.
- SD_RD_DATA_IN  out  SIZE  read-data push value.
- REF_REQ  in  1  refresh request, level, held until acknowledged.
- REF_ACK  out  1  one-cycle refresh grant.
- CMD_VALID  out  1  command valid.
- CMD_READY  in  1  command accepted.
- CMD_WRITE  out  1  1 = write, 0 = read.
- CMD_ADDR  out  SIZE  command address.
- CMD_WDATA  out  SIZE  write data.
- RSP_VALID  in  1  read response valid, one-cycle pulse.
- RSP_DATA  in  SIZE  read response data.
- BUSY  out  1  state != IDLE.
- ERR  out  1  sticky read-timeout flag.

## Operation
- FIFO pops are registered: popped data is valid on the cycle after the EN strobe.
- Each EN strobe is a single-cycle pulse, asserted only when the corresponding FIFO is non-empty.
- States and transitions:
  - IDLE:
    - If REF_REQ is high: go to REFRESH.
    - Otherwise, if RW_FIFO_EMPTY is low: assert SD_RW_EN and go to DECODE.
  - REFRESH: assert REF_ACK for 1 cycle, then go to IDLE.
  - DECODE: latch SD_RW_OUT into CMD_WRITE; go to WR_WAIT if it is 1, otherwise RD_WAIT.
  - WR_WAIT: when both WADDR_FIFO_EMPTY and WDATA_FIFO_EMPTY are low, assert SD_WR_ADDR_EN and SD_WR_DATA_EN in the same cycle and go to WR_LAT.
  - WR_LAT: load CMD_ADDR and CMD_WDATA; go to CMD.
  - RD_WAIT: when RADDR_FIFO_EMPTY is low and RDATA_FIFO_FULL is low, assert SD_RD_ADDR_EN and go to RD_LAT. This reserves the push slot.
  - RD_LAT: load CMD_ADDR; go to CMD.
  - CMD: hold CMD_VALID high with CMD_WRITE, CMD_ADDR and CMD_WDATA stable until CMD_READY is high.
    - On acceptance of a write: go to IDLE.
    - On acceptance of a read: go to RD_RSP.
  - RD_RSP: on RSP_VALID, capture RSP_DATA into SD_RD_DATA_IN and go to RD_PUSH.
  - RD_PUSH: assert SD_RD_DATA_EN for 1 cycle, then go to IDLE.
- At most one transaction is outstanding. Refresh is never granted mid-transaction.
- RSP_VALID outside RD_RSP is ignored. CMD_READY while CMD_VALID is low is ignored.
- RDATA_FIFO_FULL is checked only in RD_WAIT. This block is the only writer to the read-data FIFO, so the reserved slot cannot be lost.
- When RW=1, a missing WDATA entry stalls in WR_WAIT indefinitely. WADDR is not popped alone.

## Timing
- Reset value of every output is 0; state is IDLE; ERR is cleared.
- SD_RST asserted mid-transaction returns to IDLE next cycle. Entries already popped are dropped, and CMD_VALID drops immediately.
- Best-case latency, with SD_RW_EN at cycle t:
  - WR_WAIT/RD_WAIT strobe at t+2.
  - CMD_VALID first high at t+4.
  - For reads, SD_RD_DATA_EN fires 2 cycles after RSP_VALID.
- Back-to-back: the next SD_RW_EN can occur the cycle after a write's CMD handshake or the cycle after SD_RD_DATA_EN.
- Simultaneous REF_REQ and non-empty RW FIFO in IDLE: refresh wins.

## Configuration
- SCHED_RD_TIMEOUT_EN defined:
  - An 8-bit-or-wider counter runs in RD_RSP, cleared on entry.
  - If it reaches TIMEOUT with no RSP_VALID: set ERR (sticky until SD_RST), push {SIZE{1'b1}} via RD_PUSH, and return to IDLE, so the AXI side never hangs.
- Not defined:
  - RD_RSP waits indefinitely.
  - ERR is tied to 0.
  - No counter is instantiated.

## Test plan
- Single write: RW=1, WADDR=0x100, WDATA=0xA5A5_A5A5, CMD_READY tied high -> CMD_VALID at t+4 with CMD_WRITE=1, CMD_ADDR=0x100, CMD_WDATA=0xA5A5_A5A5, one cycle; BUSY low at t+5.
- Single read: RW=0, RADDR=0x200, RSP_VALID with 0x1234_5678 three cycles after accept -> SD_RD_DATA_EN one cycle with SD_RD_DATA_IN=0x1234_5678, two cycles after RSP_VALID.
- Ordering: RW sequence 1,0,1 with CMD_READY delayed 3 cycles per command -> commands issued write, read, write; every CMD field stable while VALID is high and READY is low.
- Backpressure: RDATA_FIFO_FULL high, RW=0 queued -> no SD_RD_ADDR_EN and no CMD_VALID until FULL drops; then the read proceeds normally.
- Refresh priority: REF_REQ and non-empty RW FIFO both in IDLE -> REF_ACK pulse first, SD_RW_EN the next cycle. REF_REQ raised during CMD -> acknowledged only after the transaction completes.
- Timeout (macro on, TIMEOUT=16): read accepted, no RSP_VALID -> after 16 cycles ERR=1 and a push of 0xFFFF_FFFF. SD_RST then clears ERR and returns to IDLE; a reset during CMD drops CMD_VALID the next cycle.
